matmul_scheduler: RTL and testbench
===================================

MATMUL_SCHEDULER -- requirements
Module: matmul_scheduler

Interface
REQ-001 Parameter W, default 16: element width of the operand row.
REQ-002 Parameter N_REQ, default 4: number of requesters; legal range 2..8.
REQ-003 Parameter TIMEOUT, default 64: maximum WAIT cycles before abort; legal range 4..255.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  N_REQ  per-requester request strobe.
REQ-007 req_a  input  N_REQ*8*W  per-requester operand row; slice i holds 8 signed W-bit elements, element 0 in LSBs.
REQ-008 req_ready  output  N_REQ  one-hot grant; a request transfers when req_valid[i] and req_ready[i] are both high.
REQ-009 mm_a  output  8*W  operand row driven to the shared row-by-matrix multiply unit.
REQ-010 mm_go  output  1  one-cycle start pulse to the multiply unit.
REQ-011 mm_out  input  8*2*W  result row from the multiply unit, 8 signed 2W-bit elements.
REQ-012 mm_out_v  input  1  result-valid level from the multiply unit.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  response consumer ready.
REQ-015 rsp_id  output  clog2(N_REQ)  index of the requester that owns the response.
REQ-016 rsp_data  output  8*2*W  captured result row.
REQ-017 rsp_err  output  1  high when the response is a timeout abort.

Function
REQ-018 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-019 In IDLE, req_ready SHALL combinationally grant the first requester with req_valid high, searching upward (wrapping) from rr_ptr; req_ready is all-zero outside IDLE or when no req_valid is high.
REQ-020 On a transfer in IDLE, the block SHALL latch req_a slice and index into the operand and id registers and move to ISSUE.
REQ-021 mm_a SHALL equal the latched operand register and remain stable from ISSUE until exit from WAIT.
REQ-022 In ISSUE, mm_go SHALL be high for exactly one cycle, the wait timer SHALL clear to 0, and the FSM SHALL move to WAIT; mm_go is low in every other state.
REQ-023 In WAIT, the timer SHALL increment each cycle; mm_out_v SHALL be ignored while the timer equals 0 (stale-valid guard).
REQ-024 In WAIT with timer >= 1 and mm_out_v high, the block SHALL capture mm_out into rsp_data, clear rsp_err, and move to RESP.
REQ-025 In WAIT, when the timer reaches TIMEOUT-1 without a capture, the block SHALL load rsp_data with zero, set rsp_err, and move to RESP; a capture in that same cycle wins over the timeout.
REQ-026 Minimum latency: transfer at cycle T, mm_go at T+1, earliest capture at T+3, rsp_valid high from T+4.
REQ-027 In RESP, rsp_valid SHALL be high and rsp_id, rsp_data, rsp_err held stable until rsp_ready is high; on that cycle, rr_ptr SHALL become (rsp_id+1) mod N_REQ and the FSM SHALL return to IDLE.
REQ-028 rsp_valid SHALL be low in all states except RESP; no new request is accepted in the rsp_ready handshake cycle.
REQ-029 Changes of req_valid or req_a while not in IDLE SHALL have no effect on the in-flight operation.
REQ-030 Captured results SHALL be passed through bit-exact; no rounding or saturation.

Reset
REQ-031 While rst is low: state IDLE, rr_ptr 0, timer 0, operand register 0, rsp_data 0, rsp_id 0, rsp_err 0; outputs req_ready 0, mm_go 0, rsp_valid 0, mm_a 0.
REQ-032 Reset asserted mid-operation (ISSUE, WAIT or RESP) SHALL abandon the operation with no response emitted; the first grant after release follows from rr_ptr 0.

Verification
REQ-033 Single request: N_REQ=4, req_valid=0010 at T, model mm_out_v high at T+3 with mm_out element0=0x00001234 -> mm_go at T+1, rsp_valid at T+4, rsp_id=1, rsp_data element0=0x00001234, rsp_err=0.
REQ-034 Round robin: all req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0 across five operations.
REQ-035 Stale valid: mm_out_v held high continuously -> capture occurs at timer=1 (T+3), never at timer=0 (T+2).
REQ-036 Timeout: TIMEOUT=8, mm_out_v never asserted -> rsp_valid at T+10, rsp_err=1, rsp_data=0.
REQ-037 Backpressure: rsp_ready low for 5 cycles in RESP -> rsp_valid, rsp_id, rsp_data stable throughout; req_ready stays 0 and req_a changes are ignored.
REQ-038 Reset in WAIT: rst low for 1 cycle at T+2 -> mm_go, rsp_valid, req_ready all 0; after release, requester 0 is granted first when req_valid=1111.

Source files
------------

// File: rtl/matmul_scheduler.sv
// rtl/matmul_scheduler.sv - round-robin scheduler sharing one row-by-matrix multiply unit
// among N_REQ requesters, with a stale-valid guard and a timeout abort.
module matmul_scheduler #(
  parameter int W       = 16,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*8*W-1:0]         req_a,
  output logic [N_REQ-1:0]             req_ready,
  output logic [8*W-1:0]               mm_a,
  output logic                         mm_go,
  input  logic [8*2*W-1:0]             mm_out,
  input  logic                         mm_out_v,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(N_REQ)-1:0]     rsp_id,
  output logic [8*2*W-1:0]             rsp_data,
  output logic                         rsp_err
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [IW:0] N_REQ_W = (IW+1)'(N_REQ);
  localparam logic [7:0]  T_LAST  = 8'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]      state;
  logic [IW-1:0]   rr_ptr;
  logic [7:0]      timer;
  logic [8*W-1:0]  op_reg;
  logic [IW-1:0]   gidx;
  logic            found;
  logic [IW:0]     cand;
  logic [IW:0]     ptr_nxt;

  // First valid requester at or above rr_ptr, wrapping; held off during reset.
  always_comb begin
    req_ready = '0;
    gidx      = '0;
    found     = 1'b0;
    cand      = '0;
    if (state == S_IDLE && rst) begin
      for (int k = 0; k < N_REQ; k++) begin
        cand = {1'b0, rr_ptr} + (IW+1)'(k);
        if (cand >= N_REQ_W) cand = cand - N_REQ_W;
        if (!found && req_valid[cand[IW-1:0]]) begin
          found = 1'b1;
          gidx  = cand[IW-1:0];
        end
      end
    end
    if (found) req_ready[gidx] = 1'b1;
  end

  always_comb begin
    ptr_nxt = {1'b0, rsp_id} + (IW+1)'(1);
    if (ptr_nxt >= N_REQ_W) ptr_nxt = '0;
  end

  assign mm_a      = op_reg;
  assign mm_go     = (state == S_ISSUE);
  assign rsp_valid = (state == S_RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      timer    <= '0;
      op_reg   <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            op_reg <= req_a[gidx*8*W +: 8*W];
            rsp_id <= gidx;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          timer <= timer + 8'd1;
          // A valid seen at timer 0 may be left over from the previous job.
          if (timer != 8'd0 && mm_out_v) begin
            rsp_data <= mm_out;
            rsp_err  <= 1'b0;
            state    <= S_RESP;
          end else if (timer == T_LAST) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rr_ptr <= ptr_nxt[IW-1:0];
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_scheduler.sv
// tb/tb_matmul_scheduler.sv - self-checking bench for matmul_scheduler with a
// behavioural multiply-unit responder and a round-robin/latency reference model.
module tb_matmul_scheduler;
  localparam int W  = 16;
  localparam int NR = 4;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*8*W-1:0] req_a;
  logic [NR-1:0]     req_ready;
  logic [8*W-1:0]    mm_a;
  logic              mm_go;
  logic [16*W-1:0]   mm_out;
  logic              mm_out_v;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [16*W-1:0]   rsp_data;
  logic              rsp_err;

  int n_cmp = 0;
  int n_bad = 0;
  int ptr   = 0;

  matmul_scheduler #(.W(W), .N_REQ(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_ready(req_ready),
    .mm_a(mm_a), .mm_go(mm_go), .mm_out(mm_out), .mm_out_v(mm_out_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Multiply unit stand-in: element j = a[j] * coef[j], full 2W-bit signed product.
  function automatic logic [16*W-1:0] mm_model(input logic [8*W-1:0] row);
    logic [16*W-1:0]         r;
    logic signed [W-1:0]     a;
    logic signed [W-1:0]     c;
    logic signed [2*W-1:0]   p;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      a = row[j*W +: W];
      c = W'(j*37 - 100);
      p = (2*W)'(a) * (2*W)'(c);
      r[j*2*W +: 2*W] = p;
    end
    return r;
  endfunction

  function automatic int pick(input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++)
      if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    return 0;
  endfunction

  task automatic scramble();
    for (int i = 0; i < NR*8*W/32; i++) req_a[i*32 +: 32] = $urandom;
    req_valid = NR'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts just after a rising edge, returns just after a rising edge in IDLE.
  // vstart: cycle (relative to transfer) mm_out_v rises, 0 = never.
  task automatic run_op(input logic [NR-1:0] valids, input int vstart, input int bp, input int rst_at);
    logic [8*W-1:0]  row;
    logic [16*W-1:0] exp_data;
    logic            exp_err;
    int              id;
    int              cap;
    int              resp_c;
    for (int i = 0; i < NR*8*W/32; i++) req_a[i*32 +: 32] = $urandom;
    req_valid = valids;
    id  = pick(valids);
    row = req_a[id*8*W +: 8*W];
    @(negedge clk);
    chk("grant", 256'(req_ready), 256'(4'(1) << id));
    tick();
    cap = (vstart == 0) ? 0 : ((vstart < 3) ? 3 : vstart);
    if (cap == 0 || cap > TO + 1) begin
      resp_c = TO + 2; exp_err = 1'b1; exp_data = '0;
    end else begin
      resp_c = cap + 1; exp_err = 1'b0; exp_data = mm_model(row);
    end
    for (int c = 1; c <= resp_c; c++) begin
      mm_out_v = (vstart != 0) && (c >= vstart);
      if (mm_out_v) mm_out = mm_model(row);
      else for (int i = 0; i < 8; i++) mm_out[i*32 +: 32] = $urandom;
      scramble();
      if (c == rst_at) rst = 1'b0;
      @(negedge clk);
      if (c == rst_at) begin
        chk("rst_mm_go", 256'(mm_go), 256'(0));
        chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
        chk("rst_req_ready", 256'(req_ready), 256'(0));
        chk("rst_mm_a", 256'(mm_a), 256'(0));
        tick();
        rst = 1'b1;
        mm_out_v = 1'b0;
        req_valid = '0;
        ptr = 0;
        @(negedge clk);
        chk("post_rst_rsp_valid", 256'(rsp_valid), 256'(0));
        chk("post_rst_mm_go", 256'(mm_go), 256'(0));
        tick();
        return;
      end
      chk("mm_go", 256'(mm_go), 256'(c == 1));
      chk("mm_a", 256'(mm_a), 256'(row));
      chk("req_ready_busy", 256'(req_ready), 256'(0));
      chk("rsp_valid_timing", 256'(rsp_valid), 256'(c == resp_c));
      if (c < resp_c) tick();
    end
    chk("rsp_id", 256'(rsp_id), 256'(id));
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_err", 256'(rsp_err), 256'(exp_err));
    for (int b = 0; b < bp; b++) begin
      tick();
      scramble();
      mm_out_v = 1'($urandom);
      @(negedge clk);
      chk("bp_rsp_valid", 256'(rsp_valid), 256'(1));
      chk("bp_rsp_id", 256'(rsp_id), 256'(id));
      chk("bp_rsp_data", rsp_data, exp_data);
      chk("bp_rsp_err", 256'(rsp_err), 256'(exp_err));
      chk("bp_req_ready", 256'(req_ready), 256'(0));
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("hs_rsp_valid", 256'(rsp_valid), 256'(1));
    chk("hs_req_ready", 256'(req_ready), 256'(0));
    tick();
    rsp_ready = 1'b0;
    mm_out_v  = 1'b0;
    req_valid = '0;
    ptr = (id + 1) % NR;
    @(negedge clk);
    chk("idle_rsp_valid", 256'(rsp_valid), 256'(0));
    chk("idle_mm_go", 256'(mm_go), 256'(0));
    tick();
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '1;
    req_a = '0;
    mm_out = '0;
    mm_out_v = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 256'(req_ready), 256'(0));
    chk("reset_mm_go", 256'(mm_go), 256'(0));
    chk("reset_rsp_valid", 256'(rsp_valid), 256'(0));
    chk("reset_mm_a", 256'(mm_a), 256'(0));
    chk("reset_rsp_data", rsp_data, 256'(0));
    chk("reset_rsp_id", 256'(rsp_id), 256'(0));
    chk("reset_rsp_err", 256'(rsp_err), 256'(0));
    req_valid = '0;
    tick();
    rst = 1'b1;
    tick();

    run_op(4'b0010, 3, 0, 0);
    run_op(4'b1111, 1, 0, 0);
    run_op(4'b0101, 0, 0, 0);
    run_op(4'b1011, 5, 5, 0);
    run_op(4'b1111, 0, 0, 2);
    for (int n = 0; n < 5; n++) run_op(4'b1111, $urandom_range(1, 9), 0, 0);
    for (int n = 0; n < 12; n++)
      run_op(NR'($urandom_range(1, 15)), $urandom_range(0, 12), $urandom_range(0, 3), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
